lif_neuron_array: RTL and testbench

Parametrised digital leaky-integrate-and-fire neuron array. It is the successor to the single analog LIF neuron tile. It holds N membrane potentials in registers and updates them one neuron per clock on each `step` request. Each update applies a programmable leak, a synaptic weight for every input spike, threshold firing and a refractory hold. It sits behind the TinyTapeout `ui_in`/`uo_out` wrapper as the neuron core, with spikes, status and a membrane monitor exposed to the host.

---
 rtl/lif_neuron_array.sv | 177 +++++++++++++++++
 tb/tb_lif_neuron_array.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/lif_neuron_array.sv
// Digital leaky-integrate-and-fire neuron array.
// Membrane potentials live in a register file. Each accepted step sweeps the
// neurons one per clock, then publishes the resulting spike vector.
module lif_neuron_array #(
    parameter int N_NEURONS = 4,
    parameter int V_WIDTH   = 8,
    parameter int W_WIDTH   = 4,
    parameter int R_WIDTH   = 3,
    localparam int SEL_W    = $clog2(N_NEURONS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 step,
    input  logic [N_NEURONS-1:0] in_spikes,
    input  logic [W_WIDTH-1:0]   weight,
    input  logic [V_WIDTH-1:0]   threshold,
    input  logic [2:0]           leak_shift,
    input  logic [R_WIDTH-1:0]   refrac,
    input  logic [SEL_W-1:0]     mon_sel,
    output logic [N_NEURONS-1:0] spike_out,
    output logic                 done,
    output logic                 busy,
    output logic [15:0]          spike_total,
    output logic [V_WIDTH-1:0]   mon_v
);

    typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     idx_q;
    logic [N_NEURONS-1:0] inSpikes_q;
    logic [W_WIDTH-1:0]   weight_q;
    logic [V_WIDTH-1:0]   threshold_q;
    logic [2:0]           leakShift_q;
    logic [R_WIDTH-1:0]   refrac_q;
    logic [V_WIDTH-1:0]   vMem_q   [N_NEURONS];
    logic [R_WIDTH-1:0]   refCnt_q [N_NEURONS];
    logic [N_NEURONS-1:0] stage_q;
    logic [N_NEURONS-1:0] spikeOut_q;
    logic [15:0]          spikeTotal_q;
    logic [V_WIDTH-1:0]   monV_q;

    logic                 accept;
    logic                 lastIdx;
    logic [V_WIDTH-1:0]   curV;
    logic [R_WIDTH-1:0]   curR;
    logic [V_WIDTH-1:0]   leakAmt;
    logic [V_WIDTH-1:0]   leaked;
    logic [V_WIDTH:0]     sum;
    logic [V_WIDTH-1:0]   sat;
    logic                 fire;
    logic [V_WIDTH-1:0]   vMem_d;
    logic [R_WIDTH-1:0]   refCnt_d;
    logic [N_NEURONS-1:0] pubSpikes;
    logic [15:0]          pubCount;

    assign accept  = (state_q == IDLE) && step && ena;
    assign lastIdx = (idx_q == SEL_W'(N_NEURONS - 1));

    // Next-state logic for the sweep controller
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = UPDATE;
            UPDATE:  if (lastIdx) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Per-neuron update datapath for the neuron currently addressed by idx
    always_comb begin
        curV     = vMem_q[idx_q];
        curR     = refCnt_q[idx_q];
        leakAmt  = (leakShift_q == 3'd0) ? '0 : (curV >> leakShift_q);
        leaked   = curV - leakAmt;
        sum      = {1'b0, leaked}
                 + (inSpikes_q[idx_q] ? (V_WIDTH+1)'(weight_q) : '0);
        sat      = sum[V_WIDTH] ? '1 : sum[V_WIDTH-1:0];
        fire     = 1'b0;
        vMem_d   = sat;
        refCnt_d = curR;
        if (curR != '0) begin
            vMem_d   = '0;
            refCnt_d = curR - R_WIDTH'(1);
        end else if (sat >= threshold_q) begin
            fire     = 1'b1;
            vMem_d   = '0;
            refCnt_d = refrac_q;
        end
    end

    // Spikes to publish at the end of a sweep, including the last neuron's
    always_comb begin
        pubSpikes = stage_q | (fire ? (N_NEURONS'(1) << idx_q) : '0);
        pubCount  = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            pubCount = pubCount + 16'(pubSpikes[i]);
        end
    end

    // Shadow copies of the step parameters and the sweep index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            inSpikes_q  <= '0;
            weight_q    <= '0;
            threshold_q <= '0;
            leakShift_q <= '0;
            refrac_q    <= '0;
        end else if (accept) begin
            idx_q       <= '0;
            inSpikes_q  <= in_spikes;
            weight_q    <= weight;
            threshold_q <= threshold;
            leakShift_q <= leak_shift;
            refrac_q    <= refrac;
        end else if (state_q == UPDATE && !lastIdx) begin
            idx_q <= idx_q + SEL_W'(1);
        end
    end

    // Membrane potential and refractory counter write-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                vMem_q[i]   <= '0;
                refCnt_q[i] <= '0;
            end
        end else if (state_q == UPDATE) begin
            vMem_q[idx_q]   <= vMem_d;
            refCnt_q[idx_q] <= refCnt_d;
        end
    end

    // Spike staging, publication and running spike count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q      <= '0;
            spikeOut_q   <= '0;
            spikeTotal_q <= '0;
        end else if (state_q == UPDATE) begin
            if (lastIdx) begin
                stage_q      <= '0;
                spikeOut_q   <= pubSpikes;
                spikeTotal_q <= spikeTotal_q + pubCount;
            end else begin
                stage_q <= pubSpikes;
            end
        end
    end

    // Membrane monitor, one cycle behind the selected register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            monV_q <= '0;
        end else if (int'(mon_sel) < N_NEURONS) begin
            monV_q <= vMem_q[mon_sel];
        end else begin
            monV_q <= '0;
        end
    end

    assign spike_out   = spikeOut_q;
    assign spike_total = spikeTotal_q;
    assign mon_v       = monV_q;
    assign busy        = (state_q == UPDATE);
    assign done        = (state_q == DONE);

endmodule

// File: tb/tb_lif_neuron_array.sv
// Directed self-checking bench for lif_neuron_array with four neurons.
module tb_lif_neuron_array;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ena;
    logic         step;
    logic [N-1:0] in_spikes;
    logic [3:0]   weight;
    logic [7:0]   threshold;
    logic [2:0]   leak_shift;
    logic [2:0]   refrac;
    logic [1:0]   mon_sel;
    logic [N-1:0] spike_out;
    logic         done;
    logic         busy;
    logic [15:0]  spike_total;
    logic [7:0]   mon_v;

    int errors = 0;
    int checks = 0;
    int lat;
    int dn;
    logic [7:0] vRead;

    lif_neuron_array dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .step        (step),
        .in_spikes   (in_spikes),
        .weight      (weight),
        .threshold   (threshold),
        .leak_shift  (leak_shift),
        .refrac      (refrac),
        .mon_sel     (mon_sel),
        .spike_out   (spike_out),
        .done        (done),
        .busy        (busy),
        .spike_total (spike_total),
        .mon_v       (mon_v)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One step request; returns at the negedge where done is high
    task automatic applyStimulus(input logic [N-1:0] spikes, output int latency);
        @(negedge clk);
        in_spikes = spikes;
        step      = 1'b1;
        @(negedge clk);
        step      = 1'b0;
        in_spikes = ~spikes;
        latency   = 1;
        while (!done && latency < 20) begin
            @(negedge clk);
            latency++;
        end
        checkOutput("doneSeen", 32'(done), 32'd1);
    endtask

    task automatic readV(input logic [1:0] sel, output logic [7:0] v);
        mon_sel = sel;
        @(negedge clk);
        v = mon_v;
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; step = 1'b0; in_spikes = '0;
        weight = 4'd5; threshold = 8'd8; leak_shift = 3'd0; refrac = 3'd0; mon_sel = 2'd0;
        #12 rst_n = 1'b1;

        // Build nonzero state, then reset asynchronously mid-cycle
        applyStimulus(4'b1111, lat);
        checkOutput("pre1Spikes", 32'(spike_out), 32'd0);
        applyStimulus(4'b0111, lat);
        checkOutput("pre2Spikes", 32'(spike_out), 32'b0111);
        checkOutput("pre2Total", 32'(spike_total), 32'd3);
        readV(2'd3, vRead);
        checkOutput("pre2V3", 32'(vRead), 32'd5);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("rstSpikeOut", 32'(spike_out), 32'd0);
        checkOutput("rstTotal", 32'(spike_total), 32'd0);
        checkOutput("rstMonV", 32'(mon_v), 32'd0);
        checkOutput("rstDone", 32'(done), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Latency from step acceptance to done
        applyStimulus(4'b0000, lat);
        checkOutput("latency", 32'(lat), 32'd5);
        checkOutput("latSpikes", 32'(spike_out), 32'd0);

        // Integrate and fire on neuron 0
        weight = 4'd5; threshold = 8'd12; leak_shift = 3'd0; refrac = 3'd0;
        applyStimulus(4'b0001, lat);
        readV(2'd0, vRead);
        checkOutput("intV0s1", 32'(vRead), 32'd5);
        applyStimulus(4'b0001, lat);
        readV(2'd0, vRead);
        checkOutput("intV0s2", 32'(vRead), 32'd10);
        checkOutput("intSpk2", 32'(spike_out), 32'd0);
        applyStimulus(4'b0001, lat);
        checkOutput("intSpk3", 32'(spike_out), 32'b0001);
        checkOutput("intTotal", 32'(spike_total), 32'd1);
        readV(2'd0, vRead);
        checkOutput("intV0s3", 32'(vRead), 32'd0);

        // Leak on neuron 1 after preloading to 40
        weight = 4'd10; threshold = 8'd255;
        for (int i = 0; i < 4; i++) applyStimulus(4'b0010, lat);
        readV(2'd1, vRead);
        checkOutput("leakPre", 32'(vRead), 32'd40);
        leak_shift = 3'd1;
        begin
            int leakExp [7] = '{20, 10, 5, 3, 2, 1, 1};
            for (int i = 0; i < 7; i++) begin
                applyStimulus(4'b0000, lat);
                readV(2'd1, vRead);
                checkOutput($sformatf("leakV1s%0d", i + 1), 32'(vRead), 32'(leakExp[i]));
            end
        end
        checkOutput("leakTotal", 32'(spike_total), 32'd1);

        // Refractory hold on neuron 3; neuron 1 holds 1 and fires on step 1
        threshold = 8'd1; weight = 4'd1; refrac = 3'd2; leak_shift = 3'd0;
        begin
            logic [3:0] refExp [7] = '{4'b1010, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b1000};
            for (int i = 0; i < 7; i++) begin
                applyStimulus(4'b1000, lat);
                checkOutput($sformatf("refSpk%0d", i + 1), 32'(spike_out), 32'(refExp[i]));
                readV(2'd3, vRead);
                checkOutput($sformatf("refV3s%0d", i + 1), 32'(vRead), 32'd0);
            end
        end
        checkOutput("refTotal", 32'(spike_total), 32'd5);

        // Saturation on neuron 2: 7 + 16*15 = 247, then 262 saturates to 255 and fires
        refrac = 3'd0; threshold = 8'd255; weight = 4'd7;
        applyStimulus(4'b0100, lat);
        weight = 4'd15;
        for (int i = 0; i < 16; i++) applyStimulus(4'b0100, lat);
        checkOutput("satSpk16", 32'(spike_out), 32'd0);
        readV(2'd2, vRead);
        checkOutput("satV2", 32'(vRead), 32'd247);
        applyStimulus(4'b0100, lat);
        checkOutput("satSpk17", 32'(spike_out), 32'b0100);
        checkOutput("satTotal", 32'(spike_total), 32'd6);
        readV(2'd2, vRead);
        checkOutput("satV2fire", 32'(vRead), 32'd0);

        // A step while busy is dropped
        @(negedge clk);
        in_spikes = 4'b0000;
        step      = 1'b1;
        @(negedge clk);
        checkOutput("busyHigh", 32'(busy), 32'd1);
        @(negedge clk);
        step = 1'b0;
        lat  = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("dropDone", 32'(done), 32'd1);
        dn = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) dn++;
        end
        checkOutput("extraDone", 32'(dn), 32'd0);
        checkOutput("dropTotal", 32'(spike_total), 32'd6);

        // Reset two edges into a sweep
        weight = 4'd15; threshold = 8'd255;
        @(negedge clk);
        in_spikes = 4'b1111;
        step      = 1'b1;
        @(negedge clk);
        step = 1'b0;
        @(posedge clk);
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midDone", 32'(done), 32'd0);
        checkOutput("midBusy", 32'(busy), 32'd0);
        checkOutput("midTotal", 32'(spike_total), 32'd0);
        dn = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) dn++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            readV(2'(i), vRead);
            if (done) dn++;
            checkOutput($sformatf("midV%0d", i), 32'(vRead), 32'd0);
        end
        checkOutput("midNoDone", 32'(dn), 32'd0);

        // Normal sweep after the aborted one
        weight = 4'd5; threshold = 8'd12; leak_shift = 3'd0; refrac = 3'd0;
        applyStimulus(4'b0001, lat);
        checkOutput("postLat", 32'(lat), 32'd5);
        checkOutput("postSpk", 32'(spike_out), 32'd0);
        checkOutput("postTotal", 32'(spike_total), 32'd0);
        readV(2'd0, vRead);
        checkOutput("postV0", 32'(vRead), 32'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
